// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the producer-facing and FIFO-facing signals of fifo_wr_arbiter.
//   master : arbiter side (drives ack, fifo_din, fifo_wr, owner_id, busy)
//   slave  : environment side (drives enable, req, din_req, fifo_full)
// Signals
//   enable     new bursts may start when 1
//   req        per-requester word-valid flags
//   din_req    packed requester data, requester i at [i*WIDTH +: WIDTH]
//   ack        one-hot (or zero) write acknowledge per requester
//   fifo_full  FIFO full flag, same clock domain
//   fifo_din   data to FIFO
//   fifo_wr    FIFO write strobe
//   owner_id   current burst owner
//   busy       arbiter is in a burst
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic                   enable;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] din_req;
    logic [N_REQ-1:0]       ack;
    logic                   fifo_full;
    logic [WIDTH-1:0]       fifo_din;
    logic                   fifo_wr;
    logic [ID_W-1:0]        owner_id;
    logic                   busy;

    modport master (
        input  enable, req, din_req, fifo_full,
        output ack, fifo_din, fifo_wr, owner_id, busy
    );

    modport slave (
        output enable, req, din_req, fifo_full,
        input  ack, fifo_din, fifo_wr, owner_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among N_REQ producers.
//   A grant gives one producer a burst of up to BURST_LEN words; the
//   owner's data is muxed onto fifo_din/fifo_wr, stalling on fifo_full
//   without dropping or duplicating words.
// Ports
//   clk    write-side clock
//   reset  asynchronous, active-high
//   bus    fifo_wr_arbiter_if.master (enable, req, din_req, fifo_full in;
//          ack, fifo_din, fifo_wr, owner_id, busy out)
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                reset,
    fifo_wr_arbiter_if.master   bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_ID_RST = ID_W'(N_REQ - 1);

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t           state;
    logic [ID_W-1:0]  owner_id;
    logic [ID_W-1:0]  last_id;
    logic [CNT_W-1:0] beat_cnt;
    logic             busy;

    logic             owner_req;
    logic             accept;
    logic             pick_valid;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  cand;
    logic [N_REQ-1:0] ack;

    // Round-robin scan starting just after the last granted requester.
    // The modulo keeps the wrap correct for non-power-of-2 N_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last_id) + k) % N_REQ);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    assign owner_req = bus.req[owner_id];
    assign accept    = (state == BURST) && owner_req && !bus.fifo_full;

    always_comb begin
        ack = '0;
        if (accept) ack[owner_id] = 1'b1;
    end

    assign bus.ack      = ack;
    assign bus.fifo_wr  = accept;
    assign bus.fifo_din = accept ? bus.din_req[owner_id*WIDTH +: WIDTH] : '0;
    assign bus.owner_id = owner_id;
    assign bus.busy     = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner_id <= '0;
            last_id  <= LAST_ID_RST;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable && pick_valid) begin
                        owner_id <= pick;
                        last_id  <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    // Early release wins over a stall: a dropped request
                    // ends the burst even while the FIFO is full.
                    if (!owner_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
